npc_redirect_unit: RTL and testbench
====================================

NPC_REDIRECT_UNIT -- requirements
Module: npc_redirect_unit

Interface
REQ-001 The block SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL provide parameter TRAP_VECTOR, default 32'h0000_0100, the redirect address on a misaligned branch/jump target.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstN, input, 1, the reset; asynchronous and active-low.
REQ-005 The block SHALL have port exValid, input, 1, execute-stage control-transfer result valid this cycle.
REQ-006 The block SHALL have port exTaken, input, 1, branch taken, or JAL/JALR.
REQ-007 The block SHALL have port exTarget, input, 32, computed next PC (npc operand sum from execute).
REQ-008 The block SHALL have port exPc, input, 32, PC of the resolving instruction.
REQ-009 The block SHALL have port fetchReady, input, 1, fetch memory accepts the current request.
REQ-010 The block SHALL have port fetchValid, output, 1, fetch request valid.
REQ-011 The block SHALL have port fetchPc, output, 32, fetch request address.
REQ-012 The block SHALL have port fetchKill, output, 1, the current request is wrong-path; its response SHALL be discarded.
REQ-013 The block SHALL have port flush, output, 1, kill IF/ID contents and responses of all requests accepted before this cycle.
REQ-014 The block SHALL have port excValid, output, 1, misaligned-target exception pulse.
REQ-015 The block SHALL have ports excPc and excTarget, outputs, 32 each, the PC of the faulting instruction and its bad target.

Function
REQ-016 Redirect event: exValid & exTaken in cycle N; redirect address SHALL be exTarget if exTarget[1:0]==2'b00, else TRAP_VECTOR.
REQ-017 exValid with exTaken=0 SHALL have no effect.
REQ-018 States: RUN, PEND; 32-bit pc register; 32-bit pendTarget register.
REQ-019 fetchValid SHALL be 1 in both states out of reset; fetchPc SHALL equal pc.
REQ-020 Handshake: a request SHALL complete when fetchValid & fetchReady; fetchPc SHALL stay stable until completion.
REQ-021 RUN, no redirect, handshake: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-022 RUN, no redirect, no handshake: pc SHALL hold.
REQ-023 RUN, redirect, handshake: pc <= redirect address; state SHALL remain RUN.
REQ-024 RUN, redirect, no handshake: pendTarget <= redirect address; state -> PEND; pc SHALL hold.
REQ-025 PEND: fetchKill SHALL be 1, combinationally; in RUN fetchKill SHALL be 0.
REQ-026 PEND, handshake: pc <= pendTarget, or the new redirect address if a redirect occurs the same cycle; state -> RUN.
REQ-027 PEND, no handshake, redirect: pendTarget SHALL be overwritten; the later redirect wins.
REQ-028 flush SHALL be registered, high exactly in cycle N+1 for each redirect event in cycle N; back-to-back events SHALL give back-to-back pulses.
REQ-029 Misaligned target: in cycle N+1, excValid SHALL be 1, excPc = exPc(N), and excTarget = exTarget(N).
REQ-030 excPc and excTarget SHALL hold their last values when excValid is 0.
REQ-031 Latency: with fetchReady=1, a redirect in cycle N SHALL present fetchPc = redirect address in cycle N+1.

Reset
REQ-032 While rstN=0, outputs SHALL be: pc=RESET_VECTOR, state=RUN, pendTarget=0, fetchValid=0, fetchKill=0, flush=0, excValid=0, excPc=0, excTarget=0.
REQ-033 Reset assertion SHALL take effect immediately, including mid-PEND; any pending redirect SHALL be discarded.
REQ-034 fetchValid SHALL rise on the first rising clk edge after rstN deasserts, with fetchPc=RESET_VECTOR.

Verification
REQ-035 Release reset, fetchReady=1 for 4 cycles -> fetchPc 0x0, 0x4, 0x8, 0xC; flush, fetchKill and excValid stay 0.
REQ-036 fetchReady=1, exValid=exTaken=1, exTarget=0x200 in cycle N -> fetchPc=0x200 and flush=1 in N+1; fetchPc=0x204 in N+2.
REQ-037 fetchReady=0, redirect to 0x300 in cycle N -> fetchPc holds its old value with fetchKill=1 from N+1. Then fetchReady=1 in cycle M -> fetchPc=0x300 and fetchKill=0 in M+1.
REQ-038 In PEND, redirect to 0x400, then to 0x500 while fetchReady=0, then handshake -> fetchPc=0x500; flush pulses twice.
REQ-039 Redirect with exTarget=0x202, exPc=0x80 -> in N+1: excValid=1, excPc=0x80, excTarget=0x202, flush=1, fetchPc=TRAP_VECTOR.
REQ-040 Start with pc=0xFFFF_FFFC: handshake -> fetchPc=0x0. Assert rstN=0 while in PEND -> outputs immediately reach REQ-032 values; after release, fetchPc=RESET_VECTOR.

Source files
------------

// File: rtl/npc_redirect_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : npc_redirect_unit_if
//  Description : Execute-resolution inputs, fetch request handshake and
//                flush/exception outputs of the next-PC redirect unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface npc_redirect_unit_if;
  // Execute-stage control-transfer resolution
  logic        exValid;
  logic        exTaken;
  logic [31:0] exTarget;
  logic [31:0] exPc;
  // Fetch request channel
  logic        fetchReady;
  logic        fetchValid;
  logic [31:0] fetchPc;
  logic        fetchKill;
  // Pipeline control and exception report
  logic        flush;
  logic        excValid;
  logic [31:0] excPc;
  logic [31:0] excTarget;

  // The redirect unit issues fetch requests
  modport master (
    input  exValid, exTaken, exTarget, exPc, fetchReady,
    output fetchValid, fetchPc, fetchKill, flush, excValid, excPc, excTarget
  );

  // Execute stage and fetch memory side
  modport slave (
    output exValid, exTaken, exTarget, exPc, fetchReady,
    input  fetchValid, fetchPc, fetchKill, flush, excValid, excPc, excTarget
  );
endinterface
`default_nettype wire

// File: rtl/npc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : npc_redirect_unit
//  Description : Holds the fetch PC, steps it on each accepted request and
//                redirects it on taken branches/jumps resolved in execute.
//                A redirect arriving while the current request is still
//                stalled is parked until that request completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  wire logic             clk,
  input  wire logic             rstN,
  npc_redirect_unit_if.master   bus
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        fetch_valid_q;
  logic        flush_q, flush_d;
  logic        exc_valid_q, exc_valid_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] exc_target_q, exc_target_d;

  logic        w_redirect;
  logic        w_misaligned;
  logic [31:0] w_redirect_addr;
  logic        w_handshake;

  // Redirect decode: misaligned targets are steered to the trap vector
  always_comb begin
    w_redirect      = bus.exValid & bus.exTaken;
    w_misaligned    = (bus.exTarget[1:0] != 2'b00);
    w_redirect_addr = w_misaligned ? TRAP_VECTOR : bus.exTarget;
    w_handshake     = fetch_valid_q & bus.fetchReady;
  end

  // Next-state logic for the PC, the parked redirect target and the reports
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    flush_d       = w_redirect;
    exc_valid_d   = w_redirect & w_misaligned;
    exc_pc_d      = exc_pc_q;
    exc_target_d  = exc_target_q;

    if (w_redirect && w_misaligned) begin
      exc_pc_d     = bus.exPc;
      exc_target_d = bus.exTarget;
    end

    case (state_q)
      RUN: begin
        if (w_redirect) begin
          if (w_handshake) begin
            pc_d = w_redirect_addr;
          end else begin
            // Current request must stay stable; park the target
            pend_target_d = w_redirect_addr;
            state_d       = PEND;
          end
        end else if (w_handshake) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        if (w_handshake) begin
          // A redirect in the completing cycle supersedes the parked one
          pc_d    = w_redirect ? w_redirect_addr : pend_target_q;
          state_d = RUN;
        end else if (w_redirect) begin
          pend_target_d = w_redirect_addr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; reset is asynchronous so a pending redirect is dropped at once
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      pend_target_q <= 32'h0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_pc_q      <= 32'h0;
      exc_target_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      fetch_valid_q <= 1'b1;
      flush_q       <= flush_d;
      exc_valid_q   <= exc_valid_d;
      exc_pc_q      <= exc_pc_d;
      exc_target_q  <= exc_target_d;
    end
  end

  // Output mapping; the request in flight while PEND is wrong-path
  always_comb begin
    bus.fetchValid = fetch_valid_q;
    bus.fetchPc    = pc_q;
    bus.fetchKill  = (state_q == PEND);
    bus.flush      = flush_q;
    bus.excValid   = exc_valid_q;
    bus.excPc      = exc_pc_q;
    bus.excTarget  = exc_target_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_npc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_redirect_unit
//  Description : Self-checking bench for npc_redirect_unit. Each table row
//                drives one cycle of inputs; the outputs expected after the
//                following rising edge are queued and compared one cycle on.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_redirect_unit;

  localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0100;

  typedef struct {
    logic        rdy;
    logic        exv;
    logic        ext;
    logic [31:0] tgt;
    logic [31:0] expc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_kill;
    logic        e_flush;
    logic        e_exc;
    logic [31:0] e_excpc;
    logic [31:0] e_exctgt;
  } vec_t;

  logic clk;
  logic rstN;
  int   errors;
  int   checks;

  npc_redirect_unit_if bus ();

  npc_redirect_unit #(
    .RESET_VECTOR (C_RESET_VECTOR),
    .TRAP_VECTOR  (C_TRAP_VECTOR)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, ".fetchValid"}, {31'h0, bus.fetchValid}, {31'h0, e.e_valid});
    chk({tag, ".fetchPc"},    bus.fetchPc,             e.e_pc);
    chk({tag, ".fetchKill"},  {31'h0, bus.fetchKill},  {31'h0, e.e_kill});
    chk({tag, ".flush"},      {31'h0, bus.flush},      {31'h0, e.e_flush});
    chk({tag, ".excValid"},   {31'h0, bus.excValid},   {31'h0, e.e_exc});
    chk({tag, ".excPc"},      bus.excPc,               e.e_excpc);
    chk({tag, ".excTarget"},  bus.excTarget,           e.e_exctgt);
  endtask

  function automatic vec_t mk(input logic rdy, input logic exv, input logic ext,
                              input logic [31:0] tgt, input logic [31:0] expc,
                              input logic [31:0] e_pc, input logic e_kill,
                              input logic e_flush, input logic e_exc,
                              input logic [31:0] e_excpc, input logic [31:0] e_exctgt);
    vec_t v;
    v.rdy = rdy; v.exv = exv; v.ext = ext; v.tgt = tgt; v.expc = expc;
    v.e_valid = 1'b1; v.e_pc = e_pc; v.e_kill = e_kill; v.e_flush = e_flush;
    v.e_exc = e_exc; v.e_excpc = e_excpc; v.e_exctgt = e_exctgt;
    return v;
  endfunction

  vec_t vecs[$];
  vec_t sb[$];
  vec_t e;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;

    //            rdy exv ext tgt           expc          | pc            kill flush exc excPc        excTarget
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_000C, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h200,      32'h8,        32'h0000_0200, 0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0204, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h900,      32'h204,      32'h0000_0208, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h300,      32'h208,      32'h0000_0208, 1, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,        32'h0000_0208, 1, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0300, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h400,      32'h300,      32'h0000_0300, 1, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h500,      32'h304,      32'h0000_0300, 1, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0500, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 1, 32'h202,      32'h80,       C_TRAP_VECTOR, 0, 1, 1, 32'h80,       32'h202));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0104, 0, 0, 0, 32'h80,       32'h202));
    vecs.push_back(mk(0, 1, 1, 32'h600,      32'h104,      32'h0000_0104, 1, 1, 0, 32'h80,       32'h202));
    vecs.push_back(mk(1, 1, 1, 32'h700,      32'h108,      32'h0000_0700, 0, 1, 0, 32'h80,       32'h202));
    vecs.push_back(mk(1, 1, 1, 32'h703,      32'h700,      C_TRAP_VECTOR, 0, 1, 1, 32'h700,      32'h703));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 32'h100,     C_TRAP_VECTOR, 1, 1, 0, 32'h700,      32'h703));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0, 0, 0, 32'h700,      32'h703));
    vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 32'h700,      32'h703));
    vecs.push_back(mk(0, 1, 1, 32'h5,        32'h0,        32'h0000_0000, 1, 1, 1, 32'h0,        32'h5));

    // Reset state
    rstN           = 1'b0;
    bus.fetchReady = 1'b0;
    bus.exValid    = 1'b0;
    bus.exTaken    = 1'b0;
    bus.exTarget   = 32'h0;
    bus.exPc       = 32'h0;
    repeat (2) @(negedge clk);
    e = mk(0, 0, 0, 0, 0, C_RESET_VECTOR, 0, 0, 0, 32'h0, 32'h0);
    e.e_valid = 1'b0;
    chk_all("reset", e);

    // Release away from the edge; fetchValid must wait for the next rising edge
    rstN = 1'b1;
    #1;
    chk("release.fetchValid", {31'h0, bus.fetchValid}, 32'h0);

    foreach (vecs[i]) begin
      bus.fetchReady = vecs[i].rdy;
      bus.exValid    = vecs[i].exv;
      bus.exTaken    = vecs[i].ext;
      bus.exTarget   = vecs[i].tgt;
      bus.exPc       = vecs[i].expc;
      sb.push_back(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard: empty at row %0d", i);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("row%0d", i), e);
      end
    end

    // Unit is now in PEND with a trap redirect parked; reset asynchronously mid-cycle
    bus.fetchReady = 1'b0;
    bus.exValid    = 1'b0;
    bus.exTaken    = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    e = mk(0, 0, 0, 0, 0, C_RESET_VECTOR, 0, 0, 0, 32'h0, 32'h0);
    e.e_valid = 1'b0;
    chk_all("async_rst", e);

    // Release and confirm the parked redirect was discarded
    @(negedge clk);
    rstN           = 1'b1;
    bus.fetchReady = 1'b1;
    #1;
    chk("rel2.fetchValid", {31'h0, bus.fetchValid}, 32'h0);
    @(negedge clk);
    e = mk(0, 0, 0, 0, 0, C_RESET_VECTOR, 0, 0, 0, 32'h0, 32'h0);
    chk_all("rel2.first", e);
    @(negedge clk);
    e = mk(0, 0, 0, 0, 0, C_RESET_VECTOR + 32'd4, 0, 0, 0, 32'h0, 32'h0);
    chk_all("rel2.second", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
